// File: rtl/rv_dpram_arb_pkg.sv
// rv_dpram_arb_pkg -- shared definitions for the dual-master RAM arbiter.
//   NUM_MASTERS : number of masters sharing the RAM (2)
//   mst_idx_e   : master index encoding used by the round-robin pointers
//   clog2()     : constant-evaluable ceiling log2 for deriving address widths
package rv_dpram_arb_pkg;

  localparam int NUM_MASTERS = 32'sd2;

  typedef enum logic {
    MST_0 = 1'b0,
    MST_1 = 1'b1
  } mst_idx_e;

  // Ceiling log2, never below 1 so a 1-word RAM still gets a legal address port.
  function automatic int clog2(input int value);
    int res;
    int v;
    res = 32'sd0;
    v   = value - 32'sd1;
    while (v > 32'sd0) begin
      res = res + 32'sd1;
      v   = v >>> 32'sd1;
    end
    if (res == 32'sd0) begin
      res = 32'sd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/rv_dpram.sv
// rv_dpram -- simple dual-port RAM: port A write-only, port B read-only.
// Ports:
//   clk          : clock
//   wena/addra/dina : write enable, address, data (memory updated at the edge)
//   renb/addrb   : read enable, address
//   doutb        : read data, registered, valid the cycle after renb
// Contents are never reset. A same-edge write and read of one address
// returns the pre-write word.
module rv_dpram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             wena,
  input  logic [AW-1:0]    addra,
  input  logic [WIDTH-1:0] dina,
  input  logic             renb,
  input  logic [AW-1:0]    addrb,
  output logic [WIDTH-1:0] doutb
);

  logic [WIDTH-1:0] mem_q [0:DEPTH-1];
  logic [WIDTH-1:0] doutb_q;

  // Write port.
  always_ff @(posedge clk) begin
    if (wena) begin
      mem_q[addra] <= dina;
    end
  end

  // Read port; output register holds its value between reads.
  always_ff @(posedge clk) begin
    if (renb) begin
      doutb_q <= mem_q[addrb];
    end
  end

  assign doutb = doutb_q;

endmodule

// File: rtl/rv_dpram_arb_rr_arb2.sv
// rv_rr_arb2 -- 2-input round-robin arbiter with one-hot, same-cycle grant.
// Ports:
//   clk, rst : clock, synchronous active-high reset (pointer favours master 0)
//   req[1:0] : request per master
//   gnt[1:0] : one-hot grant (combinational), forced to 0 during reset
// The pointer names the master favoured on the next contended cycle and moves
// away from whichever master was granted, contended or not.
module rv_rr_arb2
  import rv_dpram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  mst_idx_e ptr_q;
  mst_idx_e ptr_d;

  // Grant selection and next pointer.
  always_comb begin
    gnt   = 2'b00;
    ptr_d = ptr_q;
    if (rst) begin
      gnt   = 2'b00;
      ptr_d = MST_0;
    end else begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (ptr_q == MST_1) ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
      if (gnt[0]) begin
        ptr_d = MST_1;
      end else if (gnt[1]) begin
        ptr_d = MST_0;
      end else begin
        ptr_d = ptr_q;
      end
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= MST_0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/rv_dpram_arb.sv
// rv_dpram_arb -- two masters sharing one simple dual-port RAM. Writes compete
// for RAM port A, reads for port B, each with its own round-robin arbiter, so
// one write and one read can be granted per cycle.
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   mN_req/mN_we            : request, 1 = write / 0 = read   (N = 0,1)
//   mN_addr/mN_wdata        : word address, write data
//   mN_gnt                  : request accepted this cycle (combinational)
//   mN_rvalid/mN_rdata      : read response one cycle after grant; rdata 0 otherwise
// Build option: define RV_DPRAM_ARB_BYPASS_EN to return the written data when a
// write and a read of the same address are granted in the same cycle; without
// it the read returns the pre-write RAM contents.
module rv_dpram_arb
  import rv_dpram_arb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m0_req,
  input  logic             m0_we,
  input  logic [AW-1:0]    m0_addr,
  input  logic [WIDTH-1:0] m0_wdata,
  output logic             m0_gnt,
  output logic             m0_rvalid,
  output logic [WIDTH-1:0] m0_rdata,
  input  logic             m1_req,
  input  logic             m1_we,
  input  logic [AW-1:0]    m1_addr,
  input  logic [WIDTH-1:0] m1_wdata,
  output logic             m1_gnt,
  output logic             m1_rvalid,
  output logic [WIDTH-1:0] m1_rdata
);

  logic [NUM_MASTERS-1:0] wr_req_s;
  logic [NUM_MASTERS-1:0] rd_req_s;
  logic [NUM_MASTERS-1:0] wr_gnt_s;
  logic [NUM_MASTERS-1:0] rd_gnt_s;
  logic                   wena_s;
  logic [AW-1:0]          addra_s;
  logic [WIDTH-1:0]       dina_s;
  logic                   renb_s;
  logic [AW-1:0]          addrb_s;
  logic [WIDTH-1:0]       ram_dout_s;
  logic [WIDTH-1:0]       rd_word_s;
  logic [NUM_MASTERS-1:0] rvalid_d;
  logic [NUM_MASTERS-1:0] rvalid_q;

  assign wr_req_s = {m1_req & m1_we,  m0_req & m0_we};
  assign rd_req_s = {m1_req & ~m1_we, m0_req & ~m0_we};

  rv_rr_arb2 u_wr_arb (
    .clk (clk),
    .rst (rst),
    .req (wr_req_s),
    .gnt (wr_gnt_s)
  );

  rv_rr_arb2 u_rd_arb (
    .clk (clk),
    .rst (rst),
    .req (rd_req_s),
    .gnt (rd_gnt_s)
  );

  // Steer the granted master's request onto each RAM port.
  always_comb begin
    wena_s = |wr_gnt_s;
    renb_s = |rd_gnt_s;
    if (wr_gnt_s[1]) begin
      addra_s = m1_addr;
      dina_s  = m1_wdata;
    end else begin
      addra_s = m0_addr;
      dina_s  = m0_wdata;
    end
    if (rd_gnt_s[1]) begin
      addrb_s = m1_addr;
    end else begin
      addrb_s = m0_addr;
    end
  end

  assign m0_gnt = wr_gnt_s[0] | rd_gnt_s[0];
  assign m1_gnt = wr_gnt_s[1] | rd_gnt_s[1];

  rv_dpram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .wena  (wena_s),
    .addra (addra_s),
    .dina  (dina_s),
    .renb  (renb_s),
    .addrb (addrb_s),
    .doutb (ram_dout_s)
  );

  assign rvalid_d = rd_gnt_s;

  // Read-response owner: a registered copy of the read winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= 2'b00;
    end else begin
      rvalid_q <= rvalid_d;
    end
  end

`ifdef RV_DPRAM_ARB_BYPASS_EN
  logic             byp_d;
  logic             byp_q;
  logic [WIDTH-1:0] byp_data_q;

  assign byp_d = wena_s & renb_s & (addra_s == addrb_s);

  // Remember a same-address write/read collision and the data written.
  always_ff @(posedge clk) begin
    if (rst) begin
      byp_q      <= 1'b0;
      byp_data_q <= {WIDTH{1'b0}};
    end else begin
      byp_q      <= byp_d;
      byp_data_q <= dina_s;
    end
  end

  assign rd_word_s = byp_q ? byp_data_q : ram_dout_s;
`else
  assign rd_word_s = ram_dout_s;
`endif

  // Response outputs; masking with rst drops a response whose grant preceded reset.
  always_comb begin
    m0_rvalid = rvalid_q[0] & ~rst;
    m1_rvalid = rvalid_q[1] & ~rst;
    if (m0_rvalid) begin
      m0_rdata = rd_word_s;
    end else begin
      m0_rdata = {WIDTH{1'b0}};
    end
    if (m1_rvalid) begin
      m1_rdata = rd_word_s;
    end else begin
      m1_rdata = {WIDTH{1'b0}};
    end
  end

endmodule

// File: tb/tb_rv_dpram_arb.sv
// tb_rv_dpram_arb -- directed self-checking bench for rv_dpram_arb.
module tb_rv_dpram_arb;

  localparam int WIDTH = 32;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;

`ifdef RV_DPRAM_ARB_BYPASS_EN
  localparam logic [31:0] EXP_COLLIDE = 32'hA5A5_A5A5;
`else
  localparam logic [31:0] EXP_COLLIDE = 32'h0000_0000;
`endif

  logic             clk;
  logic             rst;
  logic             m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [AW-1:0]    m0_addr;
  logic [WIDTH-1:0] m0_wdata, m0_rdata;
  logic             m1_req, m1_we, m1_gnt, m1_rvalid;
  logic [AW-1:0]    m1_addr;
  logic [WIDTH-1:0] m1_wdata, m1_rdata;

  int checks;
  int failures;

  rv_dpram_arb #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_gnt    (m0_gnt),
    .m0_rvalid (m0_rvalid),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_gnt    (m1_gnt),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      failures = failures + 1;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m0(input logic req, input logic we, input int addr, input logic [31:0] wdata);
    m0_req   = req;
    m0_we    = we;
    m0_addr  = AW'(addr);
    m0_wdata = wdata;
  endtask

  task automatic set_m1(input logic req, input logic we, input int addr, input logic [31:0] wdata);
    m1_req   = req;
    m1_we    = we;
    m1_addr  = AW'(addr);
    m1_wdata = wdata;
  endtask

  int          setup_addr [4] = '{1, 2, 7, 9};
  logic [31:0] setup_data [4] = '{32'h11, 32'h22, 32'h0, 32'h99};
  int          rb_addr    [3] = '{30, 31, 23};
  logic [31:0] rb_data    [3] = '{32'hA0, 32'hB1, 32'hB3};

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    set_m0(1'b0, 1'b0, 0, 32'h0);
    set_m1(1'b0, 1'b0, 0, 32'h0);
    tick();
    tick();

    // Requests during reset are not granted and produce nothing.
    set_m0(1'b1, 1'b0, 3, 32'h0);
    set_m1(1'b1, 1'b1, 4, 32'h1);
    #1;
    check_val("rst_m0_gnt", m0_gnt, 1'b0);
    check_val("rst_m1_gnt", m1_gnt, 1'b0);
    check_val("rst_rvalid", {m0_rvalid, m1_rvalid}, 2'b00);
    check_val("rst_rdata", {m0_rdata, m1_rdata}, 64'h0);
    tick();

    // Write then read-after-write of address 5.
    rst = 1'b0;
    set_m0(1'b1, 1'b1, 5, 32'hDEAD_BEEF);
    set_m1(1'b0, 1'b0, 0, 32'h0);
    #1;
    check_val("a_wr_gnt", {m0_gnt, m1_gnt}, 2'b10);
    tick();
    set_m0(1'b0, 1'b0, 0, 32'h0);
    set_m1(1'b1, 1'b0, 5, 32'h0);
    #1;
    check_val("a_rd_gnt", {m0_gnt, m1_gnt}, 2'b01);
    tick();
    set_m1(1'b0, 1'b0, 0, 32'h0);
    check_val("a_rvalid", {m0_rvalid, m1_rvalid}, 2'b01);
    check_val("a_m1_rdata", m1_rdata, 32'hDEAD_BEEF);
    check_val("a_m0_rdata", m0_rdata, 32'h0);
    tick();
    check_val("a_rvalid_once", {m0_rvalid, m1_rvalid}, 2'b00);
    check_val("a_rdata_idle", m1_rdata, 32'h0);

    // Preload known words.
    for (int i = 0; i < 4; i++) begin
      set_m0(1'b1, 1'b1, setup_addr[i], setup_data[i]);
      #1;
      check_val("setup_gnt", m0_gnt, 1'b1);
      tick();
    end
    set_m0(1'b0, 1'b0, 0, 32'h0);

    // Both masters read continuously: grants alternate with no idle cycle.
    set_m0(1'b1, 1'b0, 1, 32'h0);
    set_m1(1'b1, 1'b0, 2, 32'h0);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin
        if ((k % 2) == 1) begin
          check_val("b_rvalid_m0", {m0_rvalid, m1_rvalid}, 2'b10);
          check_val("b_rdata_m0", m0_rdata, 32'h11);
        end else begin
          check_val("b_rvalid_m1", {m0_rvalid, m1_rvalid}, 2'b01);
          check_val("b_rdata_m1", m1_rdata, 32'h22);
        end
      end
      #1;
      check_val("b_gnt", {m0_gnt, m1_gnt}, ((k % 2) == 0) ? 2'b10 : 2'b01);
      tick();
    end
    check_val("b_rvalid_last", {m0_rvalid, m1_rvalid}, 2'b01);
    check_val("b_rdata_last", m1_rdata, 32'h22);
    set_m0(1'b0, 1'b0, 0, 32'h0);
    set_m1(1'b0, 1'b0, 0, 32'h0);
    tick();

    // Same-cycle write and read of address 7.
    set_m0(1'b1, 1'b1, 7, 32'hA5A5_A5A5);
    set_m1(1'b1, 1'b0, 7, 32'h0);
    #1;
    check_val("c_gnt", {m0_gnt, m1_gnt}, 2'b11);
    tick();
    set_m0(1'b0, 1'b0, 0, 32'h0);
    set_m1(1'b0, 1'b0, 0, 32'h0);
    check_val("c_rvalid", {m0_rvalid, m1_rvalid}, 2'b01);
    check_val("c_rdata", m1_rdata, EXP_COLLIDE);
    set_m1(1'b1, 1'b0, 7, 32'h0);
    #1;
    check_val("c_reread_gnt", m1_gnt, 1'b1);
    tick();
    set_m1(1'b0, 1'b0, 0, 32'h0);
    check_val("c_reread_data", m1_rdata, 32'hA5A5_A5A5);

    // Write and read of different addresses together.
    set_m0(1'b1, 1'b1, 9, 32'h55);
    set_m1(1'b1, 1'b0, 1, 32'h0);
    #1;
    check_val("d_gnt", {m0_gnt, m1_gnt}, 2'b11);
    tick();
    set_m0(1'b0, 1'b0, 0, 32'h0);
    set_m1(1'b0, 1'b0, 0, 32'h0);
    check_val("d_m1_rdata", m1_rdata, 32'h11);
    set_m0(1'b1, 1'b0, 9, 32'h0);
    #1;
    check_val("d_rd9_gnt", m0_gnt, 1'b1);
    tick();
    set_m0(1'b0, 1'b0, 0, 32'h0);
    check_val("d_rd9_data", m0_rdata, 32'h55);

    // Reset right after a read grant suppresses the response and resets pointers.
    set_m0(1'b1, 1'b0, 2, 32'h0);
    #1;
    check_val("e_gnt", m0_gnt, 1'b1);
    tick();
    rst = 1'b1;
    set_m0(1'b0, 1'b0, 0, 32'h0);
    #1;
    check_val("e_rvalid_suppr", m0_rvalid, 1'b0);
    check_val("e_rdata_zero", m0_rdata, 32'h0);
    tick();
    rst = 1'b0;
    set_m0(1'b1, 1'b0, 1, 32'h0);
    set_m1(1'b1, 1'b0, 2, 32'h0);
    #1;
    check_val("e_post_gnt", {m0_gnt, m1_gnt}, 2'b10);
    check_val("e_post_rvalid", {m0_rvalid, m1_rvalid}, 2'b00);
    tick();
    set_m0(1'b0, 1'b0, 0, 32'h0);
    check_val("e_m0_rdata", m0_rdata, 32'h11);
    #1;
    check_val("e_m1_gnt", {m0_gnt, m1_gnt}, 2'b01);
    tick();
    set_m1(1'b0, 1'b0, 0, 32'h0);
    check_val("e_m1_rdata", m1_rdata, 32'h22);

    // m1 sole writer, then both write: m0 first, m1 (holding) next.
    for (int i = 0; i < 4; i++) begin
      set_m1(1'b1, 1'b1, 20 + i, 32'hB0 + 32'(i));
      #1;
      check_val("f_sole_gnt", {m0_gnt, m1_gnt}, 2'b01);
      tick();
    end
    set_m0(1'b1, 1'b1, 30, 32'hA0);
    set_m1(1'b1, 1'b1, 31, 32'hB1);
    #1;
    check_val("f_both_gnt1", {m0_gnt, m1_gnt}, 2'b10);
    tick();
    set_m0(1'b0, 1'b0, 0, 32'h0);
    #1;
    check_val("f_both_gnt2", {m0_gnt, m1_gnt}, 2'b01);
    tick();
    set_m1(1'b0, 1'b0, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      set_m0(1'b1, 1'b0, rb_addr[i], 32'h0);
      tick();
      set_m0(1'b0, 1'b0, 0, 32'h0);
      check_val("f_readback", m0_rdata, rb_data[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv_dpram_arb.md
RV_DPRAM_ARB -- requirements
Module: rv_dpram_arb

Interface
REQ-001 Parameters SHALL be: WIDTH, default 32, data width in bits; DEPTH, default 1024, RAM word count; AW = clog2(DEPTH), derived, address width.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 mN_req  input  1  request from master N (N = 0,1).
REQ-005 mN_we  input  1  1 = write, 0 = read; qualified by mN_req.
REQ-006 mN_addr  input  AW  word address.
REQ-007 mN_wdata  input  WIDTH  write data.
REQ-008 mN_gnt  output  1  request accepted this cycle (combinational).
REQ-009 mN_rvalid  output  1  read data valid for master N.
REQ-010 mN_rdata  output  WIDTH  read data; 0 whenever mN_rvalid = 0.

Function
REQ-011 Write candidates (req & we) SHALL contend only for the RAM write port; read candidates (req & ~we) SHALL contend only for the read port; one write grant and one read grant may be issued in the same cycle.
REQ-012 Each port SHALL have an independent 2-way round-robin arbiter; with both masters contending, the master not granted last time on that port wins.
REQ-013 Priority pointer SHALL update only on a granted cycle, pointing away from the winner; an uncontended grant also moves the pointer.
REQ-014 A sole requester on a port SHALL be granted in the same cycle (zero-cycle arbitration, no bubble).
REQ-015 A non-granted master SHALL hold req/we/addr/wdata stable until gnt; the arbiter SHALL NOT store ungranted requests.
REQ-016 Granted write SHALL drive RAM wena = 1, addra, dina in the grant cycle; memory is updated at that edge.
REQ-017 Granted read SHALL drive RAM renb = 1, addrb in the grant cycle; mN_rvalid SHALL assert for exactly one cycle, one cycle after the grant, for the granted master only.
REQ-018 Back-to-back reads SHALL sustain one grant per cycle; rvalid owner SHALL be a registered copy of the read winner.
REQ-019 Write at cycle t followed by read of same address at t+1 or later SHALL return the new data.
REQ-020 Same-cycle write and read grants to the same address: behaviour per REQ-025/026.
REQ-021 Addresses are used as-is (no wrap logic); DEPTH not a power of 2 SHALL leave out-of-range addresses undefined.

Reset
REQ-022 While rst = 1: both gnt = 0, wena = renb = 0, rvalid = 0, rdata = 0, both pointers SHALL favour master 0.
REQ-023 Reset asserted in the cycle after a read grant SHALL suppress that rvalid; RAM contents SHALL NOT be cleared.
REQ-024 First cycle after rst deasserts SHALL arbitrate normally.

Configuration
REQ-025 With RV_DPRAM_ARB_BYPASS_EN defined, a same-cycle same-address write and read SHALL return the written wdata on rvalid (registered bypass flag plus wdata, selected at output).
REQ-026 Without RV_DPRAM_ARB_BYPASS_EN, that case SHALL return the pre-write RAM contents and no bypass registers SHALL exist.

Structure
REQ-027 Shared package/header SHALL hold the master count (2), the master index encoding, and the clog2 helper.
REQ-028 One sub-module rv_rr_arb2 (2-input round-robin, pointer register, one-hot grant) SHALL be instantiated twice, once per RAM port; storage SHALL be the team's rv_dpram instance.

Verification
REQ-029 Reset, then m0 write addr 5 = 0xDEADBEEF; m1 read addr 5 next cycle -> m1_gnt same cycle, m1_rvalid one cycle later, m1_rdata = 0xDEADBEEF, m0_rvalid = 0.
REQ-030 m0 and m1 both read continuously (addrs 1, 2 holding 0x11, 0x22) -> grants alternate m0, m1, m0, ...; each rvalid carries its own data; no idle cycle.
REQ-031 Same cycle: m0 write addr 7 = 0xA5A5A5A5, m1 read addr 7 (old 0x0) -> 0xA5A5A5A5 with BYPASS_EN, 0x00000000 without.
REQ-032 m0 writes, m1 reads different addresses in the same cycle -> both gnt = 1; write lands, read returns old data in one cycle.
REQ-033 Read granted, rst asserted next cycle -> no rvalid, rdata = 0; after release, m1 and m0 contend -> m0 granted first.
REQ-034 m1 sole writer 4 cycles, then m0 and m1 write together -> m0 granted first, m1 next cycle, m1 holding request stable.
